// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin arbiter feeding a single register-file write port.
// Optional conflict statistics counter enabled by defining REG_ARB_STATS_EN.
module reg_write_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int REG_INDEX = 5
) (
    input  logic                 clk,
    input  logic                 reset_enable_n,
    input  logic                 stall,
    input  logic                 req0_valid,
    input  logic [REG_INDEX-1:0] req0_num,
    input  logic [WORD_SIZE-1:0] req0_val,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [REG_INDEX-1:0] req1_num,
    input  logic [WORD_SIZE-1:0] req1_val,
    output logic                 req1_ready,
    output logic                 set_enable,
    output logic [REG_INDEX-1:0] set_num,
    output logic [WORD_SIZE-1:0] set_val
`ifdef REG_ARB_STATS_EN
    ,
    output logic [15:0]          conflict_count
`endif
);

    logic                 last_grant_q, last_grant_d;
    logic                 set_enable_q, set_enable_d;
    logic [REG_INDEX-1:0] set_num_q, set_num_d;
    logic [WORD_SIZE-1:0] set_val_q, set_val_d;
    logic                 grant0, grant1, conflict;

    // Readys are forced low during reset so nothing is handshaken while held.
    assign conflict = reset_enable_n && !stall && req0_valid && req1_valid;
    assign grant0   = reset_enable_n && !stall && req0_valid && (!req1_valid || last_grant_q);
    assign grant1   = reset_enable_n && !stall && req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign set_enable = set_enable_q;
    assign set_num    = set_num_q;
    assign set_val    = set_val_q;

    always_comb begin
        last_grant_d = last_grant_q;
        set_enable_d = 1'b0;
        set_num_d    = set_num_q;
        set_val_d    = set_val_q;
        if (grant0) begin
            last_grant_d = 1'b0;
            set_enable_d = 1'b1;
            set_num_d    = req0_num;
            set_val_d    = req0_val;
        end else if (grant1) begin
            last_grant_d = 1'b1;
            set_enable_d = 1'b1;
            set_num_d    = req1_num;
            set_val_d    = req1_val;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk or negedge reset_enable_n) begin
        if (!reset_enable_n) begin
            last_grant_q <= 1'b1;
            set_enable_q <= 1'b0;
            set_num_q    <= '0;
            set_val_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            set_enable_q <= set_enable_d;
            set_num_q    <= set_num_d;
            set_val_q    <= set_val_d;
        end
    end

`ifdef REG_ARB_STATS_EN
    logic [15:0] conflict_count_q, conflict_count_d;

    always_comb begin
        conflict_count_d = conflict_count_q;
        if (conflict && (conflict_count_q != 16'hFFFF)) begin
            conflict_count_d = conflict_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_enable_n) begin
        if (!reset_enable_n) begin
            conflict_count_q <= 16'd0;
        end else begin
            conflict_count_q <= conflict_count_d;
        end
    end

    assign conflict_count = conflict_count_q;
`else
    logic unused_conflict;
    assign unused_conflict = conflict;
`endif

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, register data width.
REQ-002 SHALL have parameter REG_INDEX, default 5, register number width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset_enable_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  high = no grant this cycle.
REQ-006 SHALL have port req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-007 SHALL have port req0_num  input  REG_INDEX  requester 0 target register.
REQ-008 SHALL have port req0_val  input  WORD_SIZE  requester 0 write data.
REQ-009 SHALL have port req0_ready  output  1  requester 0 granted this cycle.
REQ-010 SHALL have port req1_valid  input  1  requester 1 (load writeback) has a write pending.
REQ-011 SHALL have port req1_num  input  REG_INDEX  requester 1 target register.
REQ-012 SHALL have port req1_val  input  WORD_SIZE  requester 1 write data.
REQ-013 SHALL have port req1_ready  output  1  requester 1 granted this cycle.
REQ-014 SHALL have port set_enable  output  1  registered write strobe to register file.
REQ-015 SHALL have port set_num  output  REG_INDEX  registered write register number.
REQ-016 SHALL have port set_val  output  WORD_SIZE  registered write data.

Function
REQ-017 SHALL hold one state bit last_grant (0 = req0 last served, 1 = req1 last served).
REQ-018 SHALL drive reqX_ready combinationally from current valids, stall, last_grant; at most one ready high per cycle.
REQ-019 SHALL grant nothing while stall is high, whatever the valids.
REQ-020 SHALL grant the sole valid requester when exactly one valid is high and stall is low.
REQ-021 SHALL grant the requester not equal to last_grant when both valids are high and stall is low (round-robin).
REQ-022 SHALL not assert reqX_ready without reqX_valid.
REQ-023 SHALL, at posedge with a grant, load set_num/set_val from the winner, set set_enable=1, and set last_grant=winner.
REQ-024 SHALL, at posedge without a grant, set set_enable=0, hold set_num/set_val, and hold last_grant.
REQ-025 SHALL transfer a write when reqX_valid and reqX_ready are both high at the posedge; requester holds num/val stable until then.
REQ-026 SHALL present each accepted write for exactly one cycle, from the accepting posedge to the next, so the register file captures it on the intervening negedge (latency 1 cycle).
REQ-027 SHALL serialize two simultaneous writes to the same register: winner issues first, loser issues next cycle if still valid, and the loser's value is final.
REQ-028 SHALL sustain one write per cycle, with back-to-back grants under continuous valid and no idle cycle.
REQ-029 SHALL alternate grants 0,1,0,1 under continuous dual valid.

Reset
REQ-030 SHALL, on reset_enable_n low, immediately force set_enable=0, set_num=0, set_val=0, last_grant=1, and counter (if present)=0, independent of clk.
REQ-031 SHALL hold req0_ready and req1_ready low while reset_enable_n is low.
REQ-032 SHALL drop an in-flight write on reset assertion mid-cycle; requesters re-request after release.
REQ-033 SHALL give req0 priority at the first dual-valid cycle after reset release.

Configuration
REQ-034 SHALL, with macro REG_ARB_STATS_EN defined, add output conflict_count (16 bits), incremented at each posedge where both valids are high and stall is low, saturating at 16'hFFFF.
REQ-035 SHALL, without REG_ARB_STATS_EN, omit the conflict_count port and logic, leaving all other behaviour identical.

Verification
REQ-036 Only req0_valid, num=3, val=32'hDEAD -> req0_ready=1; next cycle set_enable=1, set_num=3, set_val=32'hDEAD for one cycle.
REQ-037 Both valid for 4 cycles after reset (req0 num=1, req1 num=2) -> grants 0,1,0,1; set_num sequence 1,2,1,2.
REQ-038 Both valid, same num=5, req0 val=1, req1 val=2 -> two consecutive writes to 5, values 1 then 2.
REQ-039 stall=1 with both valid for 3 cycles -> no ready and set_enable=0; after stall=0, req0 granted first.
REQ-040 Assert reset_enable_n=0 mid-cycle while set_enable=1 -> set_enable=0, set_num=0, set_val=0 before next clk edge.
REQ-041 With REG_ARB_STATS_EN, 5 dual-valid cycles -> conflict_count=5; preload to 16'hFFFE and run 3 more -> conflict_count=16'hFFFF.
